// File: rtl/psum_drain.sv
// psum_drain: pops one 3x6 psum word from a PE FIFO, requantizes it to int8 and streams it out as three 6-lane rows
module psum_drain #(
    parameter int PSUM_WIDTH = 24,
    parameter int SHIFT_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     relu_en,
    input  logic                     fifo_empty_i,
    input  logic [18*PSUM_WIDTH-1:0] fifo_dout_i,
    output logic                     fifo_rd_en_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [47:0]              out_data,
    output logic [1:0]               out_row,
    output logic                     out_last,
    output logic [15:0]              block_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t     state, state_d;
    logic [1:0] row;
    logic [7:0] q_buf [3][6];
    logic       fire;

    function automatic logic [7:0] quant(input logic [PSUM_WIDTH-1:0] x, input logic [SHIFT_W-1:0] sh, input logic relu);
        logic signed [PSUM_WIDTH:0] rnd;
        logic signed [PSUM_WIDTH:0] t;
        logic                       sat_hi;
        logic                       sat_lo;
        logic [7:0]                 q;
        int                         s;
        s      = (int'(sh) > PSUM_WIDTH - 1) ? PSUM_WIDTH - 1 : int'(sh);
        rnd    = (s > 0) ? {{PSUM_WIDTH{1'b0}}, 1'b1} << (s - 1) : '0;
        t      = ($signed({x[PSUM_WIDTH-1], x}) + rnd) >>> s;
        // in range only when bits above bit 7 all match the sign bit
        sat_hi = !t[PSUM_WIDTH] && |t[PSUM_WIDTH-1:7];
        sat_lo = t[PSUM_WIDTH] && !(&t[PSUM_WIDTH-1:7]);
        q      = sat_hi ? 8'h7f : sat_lo ? 8'h80 : t[7:0];
        return (relu && q[7]) ? 8'h00 : q;
    endfunction

    assign fire         = out_valid && out_ready;
    assign fifo_rd_en_o = rst_n && state == IDLE && enable && !fifo_empty_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = (state == IDLE) ? (fifo_rd_en_o ? LOAD : IDLE) :
                    (state == LOAD) ? EMIT :
                    (fire && row == 2'd2) ? IDLE : EMIT;
        out_valid = state == EMIT;
        out_row   = row;
        out_last  = out_valid && row == 2'd2;
        out_data  = '0;
        for (int i = 0; i < 6; i++)
            out_data[8*i +: 8] = out_valid ? q_buf[row][i] : 8'h00;
    end

    // shift/relu_en only matter at LOAD, so later changes cannot touch the block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            block_cnt <= '0;
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 6; i++)
                    q_buf[j][i] <= '0;
        end else begin
            if (state == LOAD) begin
                row <= '0;
                for (int j = 0; j < 3; j++)
                    for (int i = 0; i < 6; i++)
                        q_buf[j][i] <= quant(fifo_dout_i[(6*j+i)*PSUM_WIDTH +: PSUM_WIDTH], shift, relu_en);
            end
            if (fire) begin
                row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                if (row == 2'd2)
                    block_cnt <= block_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: table vectors, random batches against an arithmetic model, and hand sequences for timing corners
module tb_psum_drain;
    localparam int W  = 24;
    localparam int SW = 5;
    localparam int WW = 18 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          relu_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] shift = '0;
    logic          fifo_empty_i = 1'b1;
    logic [WW-1:0] fifo_dout_i = '0;
    logic          fifo_rd_en_o, out_valid, out_last;
    logic [47:0]   out_data;
    logic [1:0]    out_row;
    logic [15:0]   block_cnt;

    typedef struct {logic [47:0] d; logic [1:0] r; logic l; int c;} beat_t;
    typedef struct {int x; int sh; logic relu; logic [7:0] q;} vec_t;

    int            n_chk = 0, n_fail = 0, cyc = 0, rp = 0;
    int            viol_empty = 0, viol_b2b = 0, viol_hold = 0;
    beat_t         got[$];
    int            rd_cyc[$];
    logic [WW-1:0] fq[$];

    psum_drain #(.PSUM_WIDTH(W), .SHIFT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .shift(shift), .relu_en(relu_en),
        .fifo_empty_i(fifo_empty_i), .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(fifo_rd_en_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .block_cnt(block_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, valid the cycle after the pop
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en_o && rp < fq.size()) begin
            fifo_dout_i <= fq[rp];
            rp <= rp + 1;
        end
        fifo_empty_i <= (rp + (fifo_rd_en_o ? 1 : 0)) >= fq.size();
    end

    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, prd = 1'b0;
    logic [47:0] pd = '0;
    logic [1:0]  prw = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            prd = 1'b0;
        end else begin
            if (fifo_rd_en_o) begin
                rd_cyc.push_back(cyc);
                if (fifo_empty_i) viol_empty++;
                if (prd) viol_b2b++;
            end
            if (pv && !pr && {out_valid, out_last, out_row, out_data} !== {1'b1, pl, prw, pd}) viol_hold++;
            if (out_valid && out_ready) got.push_back('{out_data, out_row, out_last, cyc});
            pv = out_valid; pr = out_ready; pd = out_data; prw = out_row; pl = out_last; prd = fifo_rd_en_o;
        end
    end

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(output int t);
        t = -1;
        for (int k = 0; k < 60 && t < 0; k++)
            if (fifo_rd_en_o) t = cyc; else tick();
        check("rd_en_timeout", t < 0, 0);
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 400 && got.size() < n; k++) tick();
        check("beat_timeout", got.size() >= n, 1);
    endtask

    function automatic logic [7:0] qm(input longint x, input int sh, input logic relu);
        int     s = (sh > W - 1) ? W - 1 : sh;
        longint t = (x + ((s > 0) ? (longint'(1) << (s - 1)) : 64'sd0)) >>> s;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        if (relu && t < 0) t = 0;
        return t[7:0];
    endfunction

    function automatic logic [47:0] exp_row(input logic [WW-1:0] w, input int j, input int sh, input logic relu);
        logic [47:0] r = '0;
        for (int i = 0; i < 6; i++)
            r[8*i +: 8] = qm(longint'($signed(w[(6*j+i)*W +: W])), sh, relu);
        return r;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w = '0;
        int v;
        for (int e = 0; e < 18; e++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4095)) - 2048;
            w[e*W +: W] = v[W-1:0];
        end
        return w;
    endfunction

    vec_t          tbl[18];
    logic [WW-1:0] w, wa, wb;
    logic [WW-1:0] ws[5];
    logic [47:0]   exp_r;
    logic [15:0]   cnt0;
    int            t, base, r0n, k, v, sh, rl;
    int            r0[6] = '{1, -1, 127, 128, -128, -129};

    initial begin
        tbl[0]  = '{8, 4, 1'b0, 8'h01};        tbl[1]  = '{7, 4, 1'b0, 8'h00};
        tbl[2]  = '{-8, 4, 1'b0, 8'h00};       tbl[3]  = '{-9, 4, 1'b0, 8'hff};
        tbl[4]  = '{'h7fffff, 4, 1'b0, 8'h7f}; tbl[5]  = '{-9, 4, 1'b1, 8'h00};
        tbl[6]  = '{'h7fffff, 31, 1'b0, 8'h01}; tbl[7] = '{-8388608, 31, 1'b0, 8'hff};
        tbl[8]  = '{'h400000, 23, 1'b0, 8'h01}; tbl[9] = '{3, 1, 1'b0, 8'h02};
        tbl[10] = '{-3, 1, 1'b0, 8'hff};       tbl[11] = '{-5, 0, 1'b1, 8'h00};
        tbl[12] = '{5, 0, 1'b1, 8'h05};        tbl[13] = '{32767, 8, 1'b0, 8'h7f};
        tbl[14] = '{-32896, 8, 1'b0, 8'h80};   tbl[15] = '{-33000, 8, 1'b0, 8'h80};
        tbl[16] = '{200, 3, 1'b1, 8'h19};      tbl[17] = '{-200, 3, 1'b0, 8'he7};

        w = '0;
        for (int i = 0; i < 6; i++) begin
            w[i*W +: W] = r0[i][W-1:0];
            w[(6+i)*W +: W] = i[W-1:0];
            w[(12+i)*W +: W] = i[W-1:0];
        end
        fq.push_back(w);
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_last", out_last, 0);
        check("rst_cnt", block_cnt, 0);
        check("rst_rd_en", fifo_rd_en_o, 0);

        rst_n = 1'b1;
        #1;
        wait_rd(t);
        wait_beats(3);
        check("blk0_r0_data", got[0].d, 48'h80807f7fff01);
        check("blk0_r1_data", got[1].d, 48'h050403020100);
        check("blk0_r2_data", got[2].d, 48'h050403020100);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("blk0_row%0d_idx", j), got[j].r, j);
            check($sformatf("blk0_row%0d_last", j), got[j].l, j == 2);
            check($sformatf("blk0_row%0d_cyc", j), got[j].c, t + 2 + j);
        end
        check("blk0_cnt", block_cnt, 1);

        foreach (tbl[n]) begin
            k = (n * 5) % 18;
            base = got.size();
            w = '0;
            w[k*W +: W] = tbl[n].x[W-1:0];
            shift = tbl[n].sh[SW-1:0];
            relu_en = tbl[n].relu;
            fq.push_back(w);
            wait_beats(base + 3);
            exp_r = {40'b0, tbl[n].q} << (8 * (k % 6));
            check($sformatf("quant_vec%0d", n), got[base + k / 6].d, exp_r);
        end

        for (int b = 0; b < 4; b++) begin
            sh = $urandom_range(0, 31);
            rl = $urandom_range(0, 1);
            shift = sh[SW-1:0];
            relu_en = rl[0];
            base = got.size();
            cnt0 = block_cnt;
            for (int m = 0; m < 5; m++) begin
                ws[m] = rand_word();
                fq.push_back(ws[m]);
            end
            for (k = 0; k < 500 && got.size() < base + 15; k++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            out_ready = 1'b1;
            check("rand_timeout", got.size() >= base + 15, 1);
            for (int m = 0; m < 5; m++)
                for (int j = 0; j < 3; j++)
                    check($sformatf("rand_b%0d_blk%0d_row%0d", b, m, j),
                          {got[base+3*m+j].l, got[base+3*m+j].r, got[base+3*m+j].d},
                          {j == 2, j[1:0], exp_row(ws[m], j, sh, rl[0])});
            check("rand_cnt", block_cnt, 16'(cnt0 + 16'd5));
        end

        shift = '0;
        relu_en = 1'b0;
        wa = rand_word();
        wb = rand_word();
        fq.push_back(wa);
        fq.push_back(wb);
        base = got.size();
        r0n = rd_cyc.size();
        wait_rd(t);
        repeat (3) tick();
        check("bp_row1_shown", {out_valid, out_row}, {1'b1, 2'd1});
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_beats(base + 6);
        check("bp_row1_data", got[base+1].d, exp_row(wa, 1, 0, 1'b0));
        check("bp_row1_cyc", got[base+1].c, t + 6);
        check("bp_row2_cyc", got[base+2].c, t + 7);
        check("bp_next_pop", rd_cyc[r0n+1] - rd_cyc[r0n], 8);

        for (int e = 0; e < 18; e++) begin
            v = e * 37 - 300;
            wa[e*W +: W] = v[W-1:0];
        end
        wb = rand_word();
        shift = 5'd1;
        fq.push_back(wa);
        fq.push_back(wb);
        base = got.size();
        cnt0 = block_cnt;
        wait_rd(t);
        repeat (2) tick();
        enable = 1'b0;
        shift = 5'd5;
        relu_en = 1'b1;
        r0n = rd_cyc.size();
        wait_beats(base + 3);
        repeat (10) tick();
        check("en_drop_no_pop", rd_cyc.size(), r0n);
        check("en_drop_cnt", block_cnt, 16'(cnt0 + 16'd1));
        for (int j = 0; j < 3; j++)
            check($sformatf("shift_change_row%0d", j), got[base+j].d, exp_row(wa, j, 1, 1'b0));
        shift = '0;
        relu_en = 1'b0;
        enable = 1'b1;
        wait_beats(base + 6);
        for (int j = 0; j < 3; j++)
            check($sformatf("reenable_row%0d", j), got[base+3+j].d, exp_row(wb, j, 0, 1'b0));

        fq.push_back(rand_word());
        wait_rd(t);
        repeat (3) tick();
        check("rst_pre_row1", {out_valid, out_row}, {1'b1, 2'd1});
        #1 rst_n = 1'b0;
        #1;
        check("rstp_valid", out_valid, 0);
        check("rstp_data", out_data, 0);
        check("rstp_row", out_row, 0);
        check("rstp_last", out_last, 0);
        check("rstp_cnt", block_cnt, 0);
        base = got.size();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rstp_no_rows", got.size(), base);
        check("rstp_cnt_after", block_cnt, 0);

        enable = 1'b0;
        shift = 5'd3;
        for (int m = 0; m < 4; m++) begin
            ws[m] = rand_word();
            fq.push_back(ws[m]);
        end
        repeat (2) tick();
        r0n = rd_cyc.size();
        base = got.size();
        enable = 1'b1;
        wait_beats(base + 12);
        repeat (10) tick();
        check("b2b_pops", rd_cyc.size() - r0n, 4);
        for (int m = 1; m < 4; m++)
            check($sformatf("b2b_gap%0d", m), rd_cyc[r0n+m] - rd_cyc[r0n+m-1], 5);
        for (int m = 0; m < 4; m++)
            for (int j = 0; j < 3; j++)
                check($sformatf("b2b_blk%0d_row%0d", m, j),
                      {got[base+3*m+j].l, got[base+3*m+j].r, got[base+3*m+j].d},
                      {j == 2, j[1:0], exp_row(ws[m], j, 3, 1'b0)});
        check("b2b_cnt", block_cnt, 4);

        force dut.block_cnt = 16'hffff;
        tick();
        release dut.block_cnt;
        check("wrap_preload", block_cnt, 16'hffff);
        base = got.size();
        fq.push_back(rand_word());
        wait_beats(base + 3);
        tick();
        check("wrap_cnt", block_cnt, 0);

        check("rd_en_while_empty", viol_empty, 0);
        check("rd_en_consecutive", viol_b2b, 0);
        check("hold_stable", viol_hold, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required completion before 200000", $time);
        $fatal(1);
    end
endmodule
